// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter.
//   state_e   : arbiter FSM states
//   ARB_FIXED : lowest-index port always wins
//   ARB_RR    : round-robin starting after the last granted port
//   bank_ce_n : active-low chip enable for the selected bank
package mem_arbiter_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StHold,
    StDone
  } state_e;

  localparam logic [1:0] CE_NONE = 2'b11;

  // bit0 = base bank, bit1 = ext bank; exactly one is ever driven low.
  function automatic logic [1:0] bank_ce_n(input logic bank);
    return bank ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection for the SRAM arbiter.
//   req   : request vector, one bit per master
//   ptr   : index of the last granted master
//   mode  : 0 = fixed priority from index 0, 1 = round-robin from ptr+1
//   grant : one-hot grant, all zero when nothing is requested
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  input  logic                 mode,
  output logic [NUM_PORTS-1:0] grant
);

  always_comb begin
    int unsigned start;
    int unsigned idx;
    logic        found;
    grant = '0;
    found = 1'b0;
    start = mode ? (32'(ptr) + 32'd1) % NUM_PORTS : 32'd0;
    // Walk every port once starting at 'start', wrapping; first requester wins.
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = (start + i) % NUM_PORTS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-master arbiter in front of a two-bank asynchronous 32-bit SRAM.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/we/addr/sel/wdata : per-master request, held until req_ack
//   req_ack              : one-cycle completion pulse per master
//   req_rdata            : read data, valid with req_ack (held afterwards)
//   sram_addr/be_n/ce_n/oe_n/we_n : registered SRAM controls (ce_n bit0 base, bit1 ext)
//   sram_dq_o/sram_dq_oe : write data and tristate enable for the top level
//   sram_dq_i            : read data, base bank [31:0], ext bank [63:32]
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ARB_MODE    = 0,
  parameter int unsigned BANK_BIT    = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req_valid,
  input  logic [NUM_PORTS-1:0]    req_we,
  input  logic [NUM_PORTS*32-1:0] req_addr,
  input  logic [NUM_PORTS*4-1:0]  req_sel,
  input  logic [NUM_PORTS*32-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]    req_ack,
  output logic [31:0]             req_rdata,
  output logic [19:0]             sram_addr,
  output logic [3:0]              sram_be_n,
  output logic [1:0]              sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [31:0]             sram_dq_o,
  output logic                    sram_dq_oe,
  input  logic [63:0]             sram_dq_i
);

  localparam int unsigned    PtrW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0]     WaitLast  = 4'(WAIT_CYCLES);
  // Last-granted = highest index so the first search starts at port 0.
  localparam logic [PtrW-1:0] PtrReset = PtrW'(NUM_PORTS - 1);
  localparam logic           RrMode    = (ARB_MODE == ARB_RR);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [PtrW-1:0]  ptr_q;
  logic [PtrW-1:0]  gnt_idx_q;
  logic             we_q;
  logic             bank_q;

  logic [NUM_PORTS-1:0] grant;
  logic [PtrW-1:0]      gnt_idx;
  logic                 sel_we;
  logic [31:0]          sel_addr;
  logic [3:0]           sel_sel;
  logic [31:0]          sel_wdata;
  logic                 sel_bank;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PtrW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .mode  (RrMode),
    .grant (grant)
  );

  // Encode the one-hot grant and mux the winning master's request fields.
  always_comb begin
    gnt_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_sel   = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        gnt_idx   = PtrW'(i);
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*32 +: 32];
        sel_sel   = req_sel[i*4 +: 4];
        sel_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  assign sel_bank = sel_addr[BANK_BIT];

  // Only [21:2] and the bank bit reach the SRAM; the rest is ignored by design.
  logic unused_addr;
  assign unused_addr = ^sel_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ptr_q      <= PtrReset;
      gnt_idx_q  <= '0;
      we_q       <= 1'b0;
      bank_q     <= 1'b0;
      req_ack    <= '0;
      req_rdata  <= '0;
      sram_addr  <= '0;
      sram_be_n  <= 4'hF;
      sram_ce_n  <= CE_NONE;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req_valid) begin
            state_q    <= StAccess;
            cnt_q      <= '0;
            ptr_q      <= gnt_idx;
            gnt_idx_q  <= gnt_idx;
            we_q       <= sel_we;
            bank_q     <= sel_bank;
            sram_addr  <= sel_addr[21:2];
            sram_be_n  <= ~sel_sel;
            sram_ce_n  <= bank_ce_n(sel_bank);
            sram_oe_n  <= sel_we;
            sram_we_n  <= ~sel_we;
            sram_dq_o  <= sel_we ? sel_wdata : 32'h0;
            sram_dq_oe <= sel_we;
          end
        end
        StAccess: begin
          if (cnt_q == WaitLast) begin
            if (we_q) begin
              // Release we_n one cycle before ce_n/addr/dq for write hold time.
              state_q   <= StHold;
              sram_we_n <= 1'b1;
            end else begin
              state_q    <= StDone;
              req_rdata  <= bank_q ? sram_dq_i[63:32] : sram_dq_i[31:0];
              req_ack    <= NUM_PORTS'(1) << gnt_idx_q;
              sram_addr  <= '0;
              sram_be_n  <= 4'hF;
              sram_ce_n  <= CE_NONE;
              sram_oe_n  <= 1'b1;
              sram_we_n  <= 1'b1;
              sram_dq_o  <= '0;
              sram_dq_oe <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StHold: begin
          state_q    <= StDone;
          req_ack    <= NUM_PORTS'(1) << gnt_idx_q;
          sram_addr  <= '0;
          sram_be_n  <= 4'hF;
          sram_ce_n  <= CE_NONE;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_dq_o  <= '0;
          sram_dq_oe <= 1'b0;
        end
        StDone: begin
          state_q <= StIdle;
          req_ack <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: three instances cover
// fixed priority with 2 wait states (a), round-robin over 4 ports (b),
// and zero wait states (c). Acks are matched against a scoreboard queue.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance a: NUM_PORTS=2, WAIT_CYCLES=2, fixed priority
  logic [1:0]  a_valid, a_we, a_ack, a_ce_n;
  logic [63:0] a_addr, a_wdata, a_dq_i;
  logic [7:0]  a_sel;
  logic [31:0] a_rdata, a_dq_o;
  logic [19:0] a_sram_addr;
  logic [3:0]  a_be_n;
  logic        a_oe_n, a_we_n, a_dq_oe;

  // Instance b: NUM_PORTS=4, WAIT_CYCLES=1, round-robin
  logic [3:0]   b_valid, b_we, b_ack, b_be_n;
  logic [127:0] b_addr, b_wdata;
  logic [15:0]  b_sel;
  logic [31:0]  b_rdata, b_dq_o;
  logic [19:0]  b_sram_addr;
  logic [1:0]   b_ce_n;
  logic         b_oe_n, b_we_n, b_dq_oe;
  logic [63:0]  b_dq_i;

  // Instance c: NUM_PORTS=2, WAIT_CYCLES=0, fixed priority
  logic [1:0]  c_valid, c_we, c_ack, c_ce_n;
  logic [63:0] c_addr, c_wdata, c_dq_i;
  logic [7:0]  c_sel;
  logic [31:0] c_rdata, c_dq_o;
  logic [19:0] c_sram_addr;
  logic [3:0]  c_be_n;
  logic        c_oe_n, c_we_n, c_dq_oe;

  // SRAM model for b/c: read data encodes the word address and the bank.
  assign b_dq_i = {32'hE000_0000 | 32'(b_sram_addr), 32'hB000_0000 | 32'(b_sram_addr)};
  assign c_dq_i = {32'hE000_0000 | 32'(c_sram_addr), 32'hB000_0000 | 32'(c_sram_addr)};

  mem_arbiter #(.NUM_PORTS(2), .WAIT_CYCLES(2), .ARB_MODE(0), .BANK_BIT(22)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr),
    .req_sel(a_sel), .req_wdata(a_wdata), .req_ack(a_ack), .req_rdata(a_rdata),
    .sram_addr(a_sram_addr), .sram_be_n(a_be_n), .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n),
    .sram_we_n(a_we_n), .sram_dq_o(a_dq_o), .sram_dq_oe(a_dq_oe), .sram_dq_i(a_dq_i)
  );

  mem_arbiter #(.NUM_PORTS(4), .WAIT_CYCLES(1), .ARB_MODE(1), .BANK_BIT(22)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr),
    .req_sel(b_sel), .req_wdata(b_wdata), .req_ack(b_ack), .req_rdata(b_rdata),
    .sram_addr(b_sram_addr), .sram_be_n(b_be_n), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n),
    .sram_we_n(b_we_n), .sram_dq_o(b_dq_o), .sram_dq_oe(b_dq_oe), .sram_dq_i(b_dq_i)
  );

  mem_arbiter #(.NUM_PORTS(2), .WAIT_CYCLES(0), .ARB_MODE(0), .BANK_BIT(22)) u_dut_c (
    .clk(clk), .rst(rst), .req_valid(c_valid), .req_we(c_we), .req_addr(c_addr),
    .req_sel(c_sel), .req_wdata(c_wdata), .req_ack(c_ack), .req_rdata(c_rdata),
    .sram_addr(c_sram_addr), .sram_be_n(c_be_n), .sram_ce_n(c_ce_n), .sram_oe_n(c_oe_n),
    .sram_we_n(c_we_n), .sram_dq_o(c_dq_o), .sram_dq_oe(c_dq_oe), .sram_dq_i(c_dq_i)
  );

  typedef struct {
    int          dut;
    int          port;
    logic [31:0] rdata;
    int          ack_cyc;
    logic [3:0]  drop;     // valid bits the master drops when it sees this ack
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] dq_base;
    logic [31:0] dq_ext;
    logic [19:0] e_addr;
    logic [1:0]  e_ce;
    logic [3:0]  e_be;
    logic [31:0] e_rdata;
  } vec_t;
  vec_t vec [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ack(input int dut, input int port, input logic [31:0] rdata,
                            input int ack_cyc, input logic [3:0] drop);
    exp_t e;
    e.dut = dut; e.port = port; e.rdata = rdata; e.ack_cyc = ack_cyc; e.drop = drop;
    sb.push_back(e);
  endtask

  function automatic int pending(input int dut);
    int n = 0;
    foreach (sb[i]) if (sb[i].dut == dut) n++;
    return n;
  endfunction

  task automatic sb_check(input int dut, input logic [3:0] ack, input logic [31:0] rdata);
    int idx = -1;
    if (ack == 4'b0) return;
    foreach (sb[i]) if (idx < 0 && sb[i].dut == dut) idx = i;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack dut%0d: got ack 0x%0h, expected none (cycle %0d)",
               dut, ack, cyc);
      return;
    end
    chk($sformatf("dut%0d_ack_port", dut), 32'(ack), 32'(1) << sb[idx].port);
    chk($sformatf("dut%0d_rdata", dut), rdata, sb[idx].rdata);
    chk($sformatf("dut%0d_ack_cycle", dut), 32'(cyc), 32'(sb[idx].ack_cyc));
    case (dut)
      0:       a_valid &= ~sb[idx].drop[1:0];
      1:       b_valid &= ~sb[idx].drop;
      default: c_valid &= ~sb[idx].drop[1:0];
    endcase
    sb.delete(idx);
  endtask

  // Advance to the next falling edge, then score acks and SRAM protocol rules.
  task automatic tick();
    @(negedge clk);
    sb_check(0, {2'b0, a_ack}, a_rdata);
    sb_check(1, b_ack, b_rdata);
    sb_check(2, {2'b0, c_ack}, c_rdata);
    chk("a_oe_we_exclusive", 32'(a_oe_n | a_we_n), 32'd1);
    chk("b_oe_we_exclusive", 32'(b_oe_n | b_we_n), 32'd1);
    chk("c_oe_we_exclusive", 32'(c_oe_n | c_we_n), 32'd1);
    chk("a_ce_one_bank", 32'(a_ce_n != 2'b00), 32'd1);
    chk("b_ce_one_bank", 32'(b_ce_n != 2'b00), 32'd1);
    chk("c_ce_one_bank", 32'(c_ce_n != 2'b00), 32'd1);
  endtask

  task automatic drain(input int dut, input int budget);
    int n = 0;
    while (pending(dut) > 0 && n < budget) begin
      tick();
      n++;
    end
    if (pending(dut) > 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout dut%0d: got %0d acks outstanding after %0d cycles, expected 0",
               dut, pending(dut), budget);
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].dut == dut) sb.delete(i);
      case (dut)
        0:       a_valid = '0;
        1:       b_valid = '0;
        default: c_valid = '0;
      endcase
    end
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, "_ce_n"}, 32'(a_ce_n), 32'h3);
    chk({tag, "_oe_n"}, 32'(a_oe_n), 32'h1);
    chk({tag, "_we_n"}, 32'(a_we_n), 32'h1);
    chk({tag, "_be_n"}, 32'(a_be_n), 32'hF);
    chk({tag, "_dq_oe"}, 32'(a_dq_oe), 32'h0);
    chk({tag, "_addr"}, 32'(a_sram_addr), 32'h0);
  endtask

  initial begin
    automatic int t0 = 0;
    vec_t t;

    vec[0] = '{0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 32'h0,
               20'h00004, 2'b10, 4'h0, 32'hDEAD_BEEF};
    vec[1] = '{1, 1'b1, 32'h0040_0008, 4'b0011, 32'hCAFE_F00D, 32'h0, 32'h0,
               20'h00002, 2'b01, 4'b1100, 32'hDEAD_BEEF};
    vec[2] = '{1, 1'b0, 32'h0040_0100, 4'hF, 32'h0, 32'h0, 32'h1234_5678,
               20'h00040, 2'b01, 4'h0, 32'h1234_5678};
    vec[3] = '{0, 1'b1, 32'h003F_FFFC, 4'b1000, 32'hA5A5_5A5A, 32'h0, 32'h0,
               20'hFFFFF, 2'b10, 4'b0111, 32'h1234_5678};
    vec[4] = '{0, 1'b0, 32'h00C0_0004, 4'b0110, 32'h0, 32'hFFFF_FFFF, 32'h0BAD_F00D,
               20'h00001, 2'b01, 4'b1001, 32'h0BAD_F00D};

    rst = 1'b1;
    a_valid = '0; a_we = '0; a_addr = '0; a_sel = '0; a_wdata = '0; a_dq_i = '0;
    b_valid = '0; b_we = '0; b_addr = '0; b_sel = '0; b_wdata = '0;
    c_valid = '0; c_we = '0; c_addr = '0; c_sel = '0; c_wdata = '0;

    // Reset state
    tick();
    tick();
    chk("reset_a_ack", 32'(a_ack), 32'h0);
    chk("reset_a_rdata", a_rdata, 32'h0);
    chk_a_idle("reset_a");
    chk("reset_b_ce_n", 32'(b_ce_n), 32'h3);
    chk("reset_b_ack", 32'(b_ack), 32'h0);
    rst = 1'b0;
    tick();

    // Table-driven single transactions on instance a
    for (int v = 0; v < 5; v++) begin
      t  = vec[v];
      t0 = cyc;
      a_dq_i = {t.dq_ext, t.dq_base};
      a_valid[t.port]          = 1'b1;
      a_we[t.port]             = t.we;
      a_addr[t.port*32 +: 32]  = t.addr;
      a_sel[t.port*4 +: 4]     = t.sel;
      a_wdata[t.port*32 +: 32] = t.wdata;
      expect_ack(0, t.port, t.e_rdata, t0 + (t.we ? 5 : 4), 4'(1 << t.port));
      for (int k = 1; k <= 3; k++) begin
        tick();
        chk($sformatf("v%0d_access_addr", v), 32'(a_sram_addr), 32'(t.e_addr));
        chk($sformatf("v%0d_access_ce_n", v), 32'(a_ce_n), 32'(t.e_ce));
        chk($sformatf("v%0d_access_be_n", v), 32'(a_be_n), 32'(t.e_be));
        chk($sformatf("v%0d_access_oe_n", v), 32'(a_oe_n), 32'(t.we));
        chk($sformatf("v%0d_access_we_n", v), 32'(a_we_n), 32'(!t.we));
        chk($sformatf("v%0d_access_dq_oe", v), 32'(a_dq_oe), 32'(t.we));
        if (t.we) chk($sformatf("v%0d_access_dq_o", v), a_dq_o, t.wdata);
        if (k == 1) begin
          // Granted request is latched: later input changes must not leak through.
          a_addr[t.port*32 +: 32]  = ~t.addr;
          a_sel[t.port*4 +: 4]     = ~t.sel;
          a_wdata[t.port*32 +: 32] = ~t.wdata;
        end
      end
      if (t.we) begin
        tick();
        chk($sformatf("v%0d_hold_we_n", v), 32'(a_we_n), 32'h1);
        chk($sformatf("v%0d_hold_ce_n", v), 32'(a_ce_n), 32'(t.e_ce));
        chk($sformatf("v%0d_hold_addr", v), 32'(a_sram_addr), 32'(t.e_addr));
        chk($sformatf("v%0d_hold_dq_oe", v), 32'(a_dq_oe), 32'h1);
        chk($sformatf("v%0d_hold_dq_o", v), a_dq_o, t.wdata);
      end
      tick();
      chk_a_idle($sformatf("v%0d_done", v));
      drain(0, 10);
      tick();
    end

    // Fixed priority: port0 held valid starves port1
    t0 = cyc;
    a_dq_i  = {32'h0, 32'h1111_2222};
    a_we    = 2'b00;
    a_addr  = {32'h0000_0020, 32'h0000_0010};
    a_sel   = 8'hFF;
    a_valid = 2'b11;
    expect_ack(0, 0, 32'h1111_2222, t0 + 4, 4'b0000);
    expect_ack(0, 0, 32'h1111_2222, t0 + 9, 4'b0000);
    expect_ack(0, 0, 32'h1111_2222, t0 + 14, 4'b0011);
    drain(0, 40);
    tick();

    // Reset during the second ACCESS cycle of a write aborts without ack
    t0 = cyc;
    a_valid[1]      = 1'b1;
    a_we[1]         = 1'b1;
    a_addr[63:32]   = 32'h0040_0008;
    a_sel[7:4]      = 4'hF;
    a_wdata[63:32]  = 32'h1357_2468;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_we_n", 32'(a_we_n), 32'h1);
    chk("abort_ce_n", 32'(a_ce_n), 32'h3);
    chk("abort_dq_oe", 32'(a_dq_oe), 32'h0);
    chk("abort_ack", 32'(a_ack), 32'h0);
    chk("abort_rdata", a_rdata, 32'h0);
    rst = 1'b0;
    t0 = cyc;
    expect_ack(0, 1, 32'h0, t0 + 5, 4'b0010);
    drain(0, 20);
    tick();

    // Round-robin, all four ports valid: 0,1,2,3,0
    t0 = cyc;
    b_we    = '0;
    b_sel   = '1;
    b_addr  = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    b_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      expect_ack(1, i % 4, 32'hB000_0000 | 32'(32'h40 * ((i % 4) + 1)), t0 + 3 + 4 * i,
                 (i == 4) ? 4'hF : 4'h0);
    end
    drain(1, 40);
    tick();

    // Round-robin with ports 1 and 3 only: they alternate
    t0 = cyc;
    b_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      expect_ack(1, (i % 2 == 0) ? 1 : 3,
                 (i % 2 == 0) ? 32'hB000_0080 : 32'hB000_0100, t0 + 3 + 4 * i,
                 (i == 3) ? 4'hF : 4'h0);
    end
    drain(1, 40);
    tick();

    // Zero wait states: read ack at T+2, write ack at T+3
    c_sel = '1;
    t0 = cyc;
    c_valid[0]     = 1'b1;
    c_we[0]        = 1'b0;
    c_addr[31:0]   = 32'h0000_0020;
    expect_ack(2, 0, 32'hB000_0008, t0 + 2, 4'b0001);
    tick();
    chk("c_read_oe_n", 32'(c_oe_n), 32'h0);
    chk("c_read_ce_n", 32'(c_ce_n), 32'h2);
    chk("c_read_addr", 32'(c_sram_addr), 32'h8);
    drain(2, 10);
    tick();

    t0 = cyc;
    c_valid[1]     = 1'b1;
    c_we[1]        = 1'b1;
    c_addr[63:32]  = 32'h0040_0004;
    c_wdata[63:32] = 32'h0000_55AA;
    expect_ack(2, 1, 32'hB000_0008, t0 + 3, 4'b0010);
    tick();
    chk("c_write_we_n", 32'(c_we_n), 32'h0);
    chk("c_write_ce_n", 32'(c_ce_n), 32'h1);
    chk("c_write_dq_o", c_dq_o, 32'h0000_55AA);
    tick();
    chk("c_hold_we_n", 32'(c_we_n), 32'h1);
    chk("c_hold_dq_oe", 32'(c_dq_oe), 32'h1);
    drain(2, 10);
    tick();

    // Zero wait states, back to back: port0 read then port1 write
    t0 = cyc;
    c_we          = 2'b10;
    c_addr        = {32'h0040_0010, 32'h0000_0030};
    c_valid       = 2'b11;
    expect_ack(2, 0, 32'hB000_000C, t0 + 2, 4'b0001);
    expect_ack(2, 1, 32'hB000_000C, t0 + 6, 4'b0010);
    drain(2, 20);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requesting masters (2..8).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: extra SRAM access cycles beyond one (0..15).
REQ-003 SHALL have parameter ARB_MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 SHALL have parameter BANK_BIT, default 22: address bit selecting base (0) or ext (1) bank.
REQ-005 SHALL have ports clk, in, 1: the single clock. rst, in, 1: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, in, NUM_PORTS: per-port request, held until ack.
REQ-007 SHALL have ports req_we, in, NUM_PORTS (write enable); req_addr, in, NUM_PORTS*32 (byte address); req_sel, in, NUM_PORTS*4 (byte enables); req_wdata, in, NUM_PORTS*32.
REQ-008 SHALL have ports req_ack, out, NUM_PORTS (one-cycle completion pulse) and req_rdata, out, 32 (read data, valid with ack).
REQ-009 SHALL have ports sram_addr, out, 20; sram_be_n, out, 4; sram_ce_n, out, 2 (bit0 base, bit1 ext); sram_oe_n, out, 1; sram_we_n, out, 1.
REQ-010 SHALL have ports sram_dq_o, out, 32; sram_dq_oe, out, 1 (tristate enable for the top level); sram_dq_i, in, 64 (base [31:0], ext [63:32]).

Function
REQ-011 SHALL implement states IDLE, ACCESS, HOLD, DONE.
REQ-012 In IDLE with any req_valid high, SHALL grant one port, latch its we/addr/sel/wdata, and enter ACCESS next cycle; later changes to the granted port's inputs SHALL be ignored.
REQ-013 With ARB_MODE=0, SHALL grant the lowest-index valid port.
REQ-014 With ARB_MODE=1, SHALL search from (last granted index + 1) mod NUM_PORTS upward with wrap; the pointer SHALL update only on grant.
REQ-015 In ACCESS, SHALL drive sram_addr=addr[21:2], sram_be_n=~sel, and ce_n low on the bank given by addr[BANK_BIT], and SHALL stay for exactly WAIT_CYCLES+1 cycles using a 4-bit counter.
REQ-016 For reads, SHALL drive oe_n low throughout ACCESS, capture the selected bank's sram_dq_i on the last ACCESS cycle, then enter DONE.
REQ-017 For writes, SHALL drive we_n low and dq_oe high with dq_o=wdata throughout ACCESS, then enter HOLD for one cycle (we_n high; ce_n, addr and dq still driven), then enter DONE.
REQ-018 In DONE, SHALL pulse req_ack of the granted port for one cycle, hold the captured rdata (reads) or the last rdata (writes), deassert all SRAM controls, and return to IDLE.
REQ-019 Read latency: request sampled in IDLE at cycle T gives ack at T+2+WAIT_CYCLES; write ack SHALL come at T+3+WAIT_CYCLES.
REQ-020 A req_valid still high in the cycle after its ack SHALL be treated as a new request; masters drop valid on ack.
REQ-021 Outside ACCESS/HOLD, SHALL hold ce_n=2'b11, oe_n=1, we_n=1, be_n=4'hF, dq_oe=0, sram_addr=0.
REQ-022 SHALL never assert oe_n low and we_n low together, and SHALL never assert both ce_n bits low.

Reset
REQ-023 With rst high at a clock edge, SHALL enter IDLE, clear the counter, set the round-robin pointer so port 0 has top priority, set req_ack=0, req_rdata=0, and drive the idle SRAM values of REQ-021.
REQ-024 Reset mid-access SHALL abort without an ack; the aborted request SHALL be re-arbitrated after reset if its valid is still high.

Structure
REQ-025 Package mem_arbiter_pkg SHALL hold the state enumeration and the constants ARB_FIXED=0 and ARB_RR=1.
REQ-026 Grant selection SHALL be a sub-module rr_arbiter (inputs request vector, pointer, mode; output one-hot grant), purely combinational.

Verification
REQ-027 With WAIT_CYCLES=2, port0 reads 0x0000_0010 and base dq_i=0xDEADBEEF -> sram_addr=0x4, ce_n=2'b10, oe_n low for 3 cycles, ack0 at T+4, rdata=0xDEADBEEF.
REQ-028 Port1 writes 0xCAFEF00D to 0x0040_0008 with sel=4'b0011 -> ce_n=2'b01, be_n=4'b1100, we_n low for 3 cycles then one HOLD cycle, ack1 at T+5.
REQ-029 ARB_MODE=0, both ports valid continuously -> port0 granted on every arbitration and port1 is starved, as specified.
REQ-030 ARB_MODE=1, NUM_PORTS=4, all valid -> grants cycle 0,1,2,3,0; with only ports 1 and 3 valid -> they alternate.
REQ-031 rst asserted during the second ACCESS cycle of a write -> the next cycle shows we_n=1, ce_n=2'b11, dq_oe=0 and no ack; after reset release the request completes with a full-latency ack.
REQ-032 WAIT_CYCLES=0 -> read ack at T+2 and write ack at T+3; no cycle ever has oe_n and we_n both low.
